// File: rtl/debounce_edge_detect_pkg.sv
// Shared definitions for the push-button debounce front end: FSM encodings
// and the clock-derived default qualification time.
package debounce_edge_detect_pkg;

  typedef enum logic [1:0] {
    S_LOW      = 2'b00,
    S_RISE_CHK = 2'b01,
    S_HIGH     = 2'b10,
    S_FALL_CHK = 2'b11
  } state_t;

  localparam int unsigned CLK_FREQ_HZ   = 25_000_000;
  // 10 ms worth of cycles at CLK_FREQ_HZ
  localparam int unsigned DEBOUNCE_10MS = CLK_FREQ_HZ / 100;

endpackage

// File: rtl/debounce_edge_detect_if.sv
// Switch-side signal bundle: raw switch level in, debounced level and
// strobes out.
interface debounce_edge_detect_if;
  logic i_Switch;
  logic o_Switch;
  logic o_Press;
  logic o_Release;
  logic o_Busy;

  modport master (
    output i_Switch,
    input  o_Switch, o_Press, o_Release, o_Busy
  );

  modport slave (
    input  i_Switch,
    output o_Switch, o_Press, o_Release, o_Busy
  );
endinterface

// File: rtl/debounce_edge_detect_sync_ff_chain.sv
// Multi-flop synchroniser for asynchronous single-bit inputs; all stages
// reset to 0.
module sync_ff_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/debounce_edge_detect.sv
// Push-button front end: synchronise, qualify a level change for
// DEBOUNCE_LIMIT stable cycles, then emit a clean level and one-cycle strobes.
module debounce_edge_detect
  import debounce_edge_detect_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LIMIT = DEBOUNCE_10MS,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  debounce_edge_detect_if.slave  sw
);

  localparam int unsigned   CW   = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LIMIT - 1);

  state_t        state;
  logic [CW-1:0] count;
  logic          s_in;

  sync_ff_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (i_Clk),
    .rst (i_Reset),
    .d   (sw.i_Switch),
    .q   (s_in)
  );

  // o_Busy is registered alongside the state so it is high exactly while
  // the state register holds a CHK encoding.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state        <= S_LOW;
      count        <= '0;
      sw.o_Switch  <= 1'b0;
      sw.o_Press   <= 1'b0;
      sw.o_Release <= 1'b0;
      sw.o_Busy    <= 1'b0;
    end else begin
      sw.o_Press   <= 1'b0;
      sw.o_Release <= 1'b0;
      case (state)
        S_LOW: begin
          sw.o_Switch <= 1'b0;
          if (s_in) begin
            state     <= S_RISE_CHK;
            count     <= '0;
            sw.o_Busy <= 1'b1;
          end
        end
        S_RISE_CHK: begin
          if (!s_in) begin
            state     <= S_LOW;
            count     <= '0;
            sw.o_Busy <= 1'b0;
          end else if (count == LAST) begin
            state       <= S_HIGH;
            count       <= '0;
            sw.o_Busy   <= 1'b0;
            sw.o_Switch <= 1'b1;
            sw.o_Press  <= 1'b1;
          end else begin
            count <= count + CW'(1);
          end
        end
        S_HIGH: begin
          sw.o_Switch <= 1'b1;
          if (!s_in) begin
            state     <= S_FALL_CHK;
            count     <= '0;
            sw.o_Busy <= 1'b1;
          end
        end
        S_FALL_CHK: begin
          if (s_in) begin
            state     <= S_HIGH;
            count     <= '0;
            sw.o_Busy <= 1'b0;
          end else if (count == LAST) begin
            state        <= S_LOW;
            count        <= '0;
            sw.o_Busy    <= 1'b0;
            sw.o_Switch  <= 1'b0;
            sw.o_Release <= 1'b1;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: begin
          state       <= S_LOW;
          count       <= '0;
          sw.o_Busy   <= 1'b0;
          sw.o_Switch <= 1'b0;
        end
      endcase
    end
  end

endmodule
